// File: rtl/alu_thread_sched_pkg.sv
// Shared constants for the ALU thread scheduler.
// ALU_LAT is derived from the ALU register settings so the tag pipe and the
// ALU cannot drift apart.
package alu_thread_sched_pkg;

  localparam int ALU_REGS_IN    = 1;
  localparam int ALU_MID_STAGES = 4;
  localparam int ALU_REGS_OUT   = 1;

  localparam int SCHED_THREADS = 8;
  localparam int SCHED_THRD_W  = $clog2(SCHED_THREADS);
  localparam int SCHED_ALU_LAT = ALU_REGS_IN + ALU_MID_STAGES + ALU_REGS_OUT;
  localparam int SCHED_CNT_W   = 32;

  // Tag field layout {vld, thrd}
  localparam int TAG_THRD_LSB = 0;
  localparam int TAG_VLD_BIT  = SCHED_THRD_W;

endpackage

// File: rtl/alu_thread_sched_rr.sv
// Combinational rotating-priority arbiter: picks the first set request bit
// searching upward from ptr, wrapping at N-1 -> 0.
module alu_thread_sched_rr #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W:0] pos;

  // Walk positions ptr, ptr+1, ... (mod N); first requester wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (W+1)'(i);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (!any && req[pos[W-1:0]]) begin
        any = 1'b1;
        idx = pos[W-1:0];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_thread_sched.sv
// Round-robin issue scheduler for a shared pipelined ALU.
// Stage 0 of the tag pipe is the issue register; stage ALU_LAT lines up with
// the ALU result. Optional perf counters: define ALU_SCHED_CNT_EN.
module alu_thread_sched
  import alu_thread_sched_pkg::*;
#(
  parameter int THREADS = SCHED_THREADS,
  parameter int THRD_W  = SCHED_THRD_W,
  parameter int ALU_LAT = SCHED_ALU_LAT,
  parameter int CNT_W   = SCHED_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [THREADS-1:0] req_i,
  input  logic [THREADS-1:0] clr_i,
  input  logic               hold_i,
  output logic [THREADS-1:0] grant_o,
  output logic               issue_vld_o,
  output logic [THRD_W-1:0]  issue_thrd_o,
  output logic [THREADS-1:0] busy_o,
  output logic               rtn_vld_o,
  output logic [THRD_W-1:0]  rtn_thrd_o,
  output logic [CNT_W-1:0]   cnt_issue_o,
  output logic [CNT_W-1:0]   cnt_idle_o
);

  logic [THREADS-1:0]             busy, rtn_now, elig, grant;
  logic [THRD_W-1:0]              ptr, gidx;
  logic                           gany;
  logic [ALU_LAT:0]               vld_pipe;
  logic [ALU_LAT:0][THRD_W-1:0]   thrd_pipe;

  // A return racing an abort for the same thread is dropped
  assign rtn_vld_o  = vld_pipe[ALU_LAT] & ~clr_i[thrd_pipe[ALU_LAT]];
  assign rtn_thrd_o = thrd_pipe[ALU_LAT];

  // One-hot of the thread completing this cycle
  always_comb begin
    rtn_now = '0;
    if (rtn_vld_o) rtn_now[rtn_thrd_o] = 1'b1;
  end

  // A completing thread may be re-granted in the same cycle
  assign elig = req_i & ~clr_i & (~busy | rtn_now) & {THREADS{~hold_i & rst_i}};

  alu_thread_sched_rr #(.N(THREADS), .W(THRD_W)) u_rr (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign grant_o      = grant;
  assign issue_vld_o  = vld_pipe[0];
  assign issue_thrd_o = thrd_pipe[0];
  assign busy_o       = busy;

  // Tag pipe: load on grant, shift every cycle, kill tags of aborted threads
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe  <= '0;
      thrd_pipe <= '0;
    end else begin
      vld_pipe[0]  <= gany;
      thrd_pipe[0] <= gidx;
      for (int k = 1; k <= ALU_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1] & ~clr_i[thrd_pipe[k-1]];
        thrd_pipe[k] <= thrd_pipe[k-1];
      end
    end
  end

  // Busy mask: set on grant, cleared on return or abort; a re-grant wins
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) busy <= '0;
    else        busy <= (busy & ~rtn_now & ~clr_i) | grant;
  end

  // RR pointer moves past the winner; frozen when nothing is granted
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    ptr <= '0;
    else if (gany) ptr <= (gidx == THRD_W'(THREADS-1)) ? '0 : gidx + 1'b1;
  end

`ifdef ALU_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt_issue, cnt_idle;

  // Saturating perf counters: grants, and requested-but-idle cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_issue <= '0;
      cnt_idle  <= '0;
    end else begin
      if (gany && cnt_issue != '1) cnt_issue <= cnt_issue + 1'b1;
      if (!gany && |req_i && cnt_idle != '1) cnt_idle <= cnt_idle + 1'b1;
    end
  end

  assign cnt_issue_o = cnt_issue;
  assign cnt_idle_o  = cnt_idle;
`else
  assign cnt_issue_o = '0;
  assign cnt_idle_o  = '0;
`endif

endmodule

// File: tb/tb_alu_thread_sched.sv
// Bench for alu_thread_sched: timestamp-based model of in-flight ops,
// directed scenarios with literal expectations, then random traffic.
module tb_alu_thread_sched;

  localparam int NT  = 8;
  localparam int TW  = 3;
  localparam int LAT = 6;
  localparam int CW  = 32;

  logic          clk_i  = 1'b0;
  logic          rst_i  = 1'b0;
  logic [NT-1:0] req_i  = '0;
  logic [NT-1:0] clr_i  = '0;
  logic          hold_i = 1'b0;
  logic [NT-1:0] grant_o, busy_o;
  logic          issue_vld_o, rtn_vld_o;
  logic [TW-1:0] issue_thrd_o, rtn_thrd_o;
  logic [CW-1:0] cnt_issue_o, cnt_idle_o;

  alu_thread_sched #(.THREADS(NT), .THRD_W(TW), .ALU_LAT(LAT), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .clr_i(clr_i), .hold_i(hold_i),
    .grant_o(grant_o), .issue_vld_o(issue_vld_o), .issue_thrd_o(issue_thrd_o),
    .busy_o(busy_o), .rtn_vld_o(rtn_vld_o), .rtn_thrd_o(rtn_thrd_o),
    .cnt_issue_o(cnt_issue_o), .cnt_idle_o(cnt_idle_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;

  // Model: each thread is either idle or owns one op due back at a cycle number
  bit     m_live[NT];
  longint m_due[NT];
  int     m_ptr, m_it, m_gidx, m_rtn;
  bit     m_iv;
  longint cyc = 0, m_ci, m_cd;

  // Snapshots of DUT outputs taken mid-cycle
  logic [NT-1:0] s_grant, s_busy;
  logic          s_iv, s_rv;
  logic [TW-1:0] s_it, s_rt;
  logic [CW-1:0] s_cd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_live[t] = 0;
    m_ptr = 0; m_iv = 0; m_it = 0; m_ci = 0; m_cd = 0;
  endtask

  // Which op returns this cycle, and who wins arbitration
  task automatic model_eval();
    m_rtn = -1;
    for (int t = 0; t < NT; t++)
      if (m_live[t] && m_due[t] == cyc && !clr_i[t]) m_rtn = t;
    m_gidx = -1;
    if (rst_i && !hold_i)
      for (int i = 0; i < NT; i++) begin
        int t;
        t = (m_ptr + i) % NT;
        if (m_gidx < 0 && req_i[t] && !clr_i[t] && (!m_live[t] || m_rtn == t)) m_gidx = t;
      end
  endtask

  task automatic compare();
    logic [NT-1:0] eg, eb;
    eg = '0; eb = '0;
    if (m_gidx >= 0) eg[m_gidx] = 1'b1;
    for (int t = 0; t < NT; t++) eb[t] = m_live[t];
    chk("grant", grant_o, eg);
    chk("issue_vld", issue_vld_o, m_iv);
    if (m_iv) chk("issue_thrd", issue_thrd_o, m_it);
    chk("busy", busy_o, eb);
    chk("rtn_vld", rtn_vld_o, m_rtn >= 0);
    if (m_rtn >= 0) chk("rtn_thrd", rtn_thrd_o, m_rtn);
`ifdef ALU_SCHED_CNT_EN
    chk("cnt_issue", cnt_issue_o, m_ci);
    chk("cnt_idle", cnt_idle_o, m_cd);
`else
    chk("cnt_issue", cnt_issue_o, 0);
    chk("cnt_idle", cnt_idle_o, 0);
`endif
  endtask

  task automatic model_update();
    if (m_gidx >= 0) m_ci++;
    else if (req_i != '0) m_cd++;
    for (int t = 0; t < NT; t++) begin
      if (clr_i[t]) m_live[t] = 0;
      if (m_rtn == t) m_live[t] = 0;
    end
    m_iv = (m_gidx >= 0);
    m_it = (m_gidx >= 0) ? m_gidx : 0;
    if (m_gidx >= 0) begin
      m_live[m_gidx] = 1;
      m_due[m_gidx]  = cyc + 1 + LAT;
      m_ptr = (m_gidx + 1) % NT;
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, inputs change #1 later
  task automatic step();
    @(negedge clk_i);
    if (!rst_i) model_reset();
    model_eval();
    s_grant = grant_o; s_busy = busy_o; s_iv = issue_vld_o; s_it = issue_thrd_o;
    s_rv = rtn_vld_o; s_rt = rtn_thrd_o; s_cd = cnt_idle_o;
    compare();
    @(posedge clk_i);
    if (rst_i) model_update(); else model_reset();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    req_i = '0; clr_i = '0; hold_i = 1'b0; rst_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
  endtask

  initial begin
    logic any_rv;
    model_reset();
    do_reset();
    chk("reset_busy", s_busy, 0);
    chk("reset_issue", s_iv, 0);

    // Single issue: thread 2
    req_i = 8'h04; step();
    chk("t1_grant", s_grant, 8'h04);
    req_i = '0; step();
    chk("t1_issue_vld", s_iv, 1);
    chk("t1_issue_thrd", s_it, 2);
    for (int i = 2; i <= 6; i++) step();
    chk("t1_no_early_rtn", s_rv, 0);
    step();
    chk("t1_rtn_vld", s_rv, 1);
    chk("t1_rtn_thrd", s_rt, 2);

    // All requesting: strict rotation, issue every cycle
    do_reset();
    req_i = 8'hFF; step();
    for (int i = 1; i < 20; i++) begin
      step();
      chk("t2_issue_vld", s_iv, 1);
      chk("t2_order", s_it, (i - 1) % NT);
    end

    // Busy block: two threads, five idle cycles, re-grant on return cycle
    do_reset();
    req_i = 8'h03; step(); step();
    chk("t3_second", s_grant, 8'h02);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_idle", s_grant, 0);
    end
    step();
    chk("t3_regrant", s_grant, 8'h01);
    chk("t3_rtn_thrd", s_rt, 0);
`ifdef ALU_SCHED_CNT_EN
    chk("t3_cnt_idle", s_cd, 5);
`endif

    // Abort thread 3 three cycles after issue
    do_reset();
    req_i = 8'h08; step();
    req_i = '0; step(); step();
    step();
    clr_i = 8'h08; step();
    clr_i = '0; step();
    chk("t4_busy_clr", s_busy[3], 0);
    any_rv = 0;
    for (int i = 0; i < 6; i++) begin step(); any_rv |= s_rv; end
    chk("t4_no_rtn", any_rv, 0);
    req_i = 8'h08; step();
    chk("t4_regrant", s_grant, 8'h08);

    // Hold freezes grants and pointer
    do_reset();
    hold_i = 1'b1; req_i = 8'h81; step();
    chk("t5_hold", s_grant, 0);
    step();
    hold_i = 1'b0; step();
    chk("t5_release", s_grant, 8'h01);

    // Reset with ops in flight
    do_reset();
    req_i = 8'hFF;
    for (int i = 0; i < 4; i++) step();
    req_i = '0; rst_i = 1'b0; step();
    chk("t6_rst_issue", s_iv, 0);
    chk("t6_rst_busy", s_busy, 0);
    rst_i = 1'b1;
    any_rv = 0;
    for (int i = 0; i < 10; i++) begin step(); any_rv |= s_rv; end
    chk("t6_no_rtn", any_rv, 0);
    req_i = 8'hFF; step();
    chk("t6_first", s_grant, 8'h01);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NT-1:0] c;
      hold_i = ($urandom_range(0, 9) == 0);
      req_i  = ($urandom_range(0, 1) == 0) ? NT'($urandom) : NT'($urandom & $urandom);
      c = '0;
      for (int t = 0; t < NT; t++) c[t] = ($urandom_range(0, 39) == 0);
      clr_i = c;
      rst_i = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_i = 1'b1; req_i = '0; clr_i = '0; hold_i = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
